// File: rtl/sa_ctrl_pkg.sv
// Shared state type and phase-length helpers for the systolic-array sequencer.
// The stream counter width leaves headroom for K = 2^K_WIDTH-1 plus skew.
package sa_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, COMMIT, STREAM, DONE} seq_state_e;

   function automatic int streamCntWidth(input int kWidth, input int rows, input int cols);
      return kWidth + $clog2(rows + cols) + 2;
   endfunction

   function automatic int loadLen(input int rows, input int peLat);
      return rows * peLat;
   endfunction

   function automatic int commitLen(input int rows, input int cols, input int peLat);
      return (cols - 1) + rows * peLat;
   endfunction

   function automatic logic [63:0] streamLen(input int rows, input int cols, input int peLat,
                                             input logic [63:0] k);
      return k + 64'((rows + cols - 1) * peLat);
   endfunction

endpackage

// File: rtl/sa_skew_gen.sv
// N-lane skewed window generator: lane n is enabled for K cycles starting
// BASE + n*STRIDE cycles after the start pulse. Outputs are registered.
module sa_skew_gen #(
   parameter int N       = 1,
   parameter int K_WIDTH = 16,
   parameter int CNT_W   = 20,
   parameter int BASE    = 0,
   parameter int STRIDE  = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [K_WIDTH-1:0] k_i,
   output logic [N-1:0]       vld_o
);

   logic             active_q, active_d;
   logic [CNT_W-1:0] t_q, t_d;
   logic [N-1:0]     vld_q, vld_d;

   function automatic logic [CNT_W-1:0] laneLo(input int n);
      return CNT_W'(BASE + n * STRIDE);
   endfunction

   // Windows are evaluated on the next-cycle count so the registered enables line up with it.
   always_comb begin
      active_d = active_q;
      t_d      = t_q;
      vld_d    = '0;
      if (start_i) begin
         active_d = 1'b1;
         t_d      = '0;
      end else if (stop_i) begin
         active_d = 1'b0;
         t_d      = '0;
      end else if (active_q) begin
         t_d = t_q + CNT_W'(1);
      end
      for (int n = 0; n < N; n++) begin
         vld_d[n] = active_d && (t_d >= laneLo(n)) && (t_d < laneLo(n) + CNT_W'(k_i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         t_q      <= '0;
         vld_q    <= '0;
      end else begin
         active_q <= active_d;
         t_q      <= t_d;
         vld_q    <= vld_d;
      end
   end

   assign vld_o = vld_q;

endmodule

// File: rtl/sa_seq_ctrl.sv
// Job sequencer for the systolic array: weight load, skewed commit, skewed stream, done.
// Optional SA_SEQ_CTRL_PERF_EN adds o_perf_cycles, a saturating per-job busy-cycle count.
module sa_seq_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int SA_ROWS = 3,
   parameter int SA_COLS = 1,
   parameter int K_WIDTH = 16,
   parameter int PE_LAT  = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [K_WIDTH-1:0]       i_k_len,
   input  logic                     i_abort,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_w_load,
   output logic [$clog2(SA_ROWS):0] o_w_row_idx,
   output logic [SA_COLS-1:0]       o_ctrl_sa_send_data,
   output logic [SA_ROWS-1:0]       o_a_vld,
   output logic [SA_COLS-1:0]       o_c_vld
`ifdef SA_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]              o_perf_cycles
`endif
);

   localparam int CNT_W = streamCntWidth(K_WIDTH, SA_ROWS, SA_COLS);
   localparam int IDX_W = $clog2(SA_ROWS) + 1;
   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(loadLen(SA_ROWS, PE_LAT) - 1);
   localparam logic [CNT_W-1:0] COMMIT_LAST = CNT_W'(commitLen(SA_ROWS, SA_COLS, PE_LAT) - 1);

   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [K_WIDTH-1:0] k_q, k_d;
   logic [IDX_W-1:0]   wRowIdx_q, wRowIdx_d;
   logic               wLoad_q, wLoad_d;
   logic [SA_COLS-1:0] sendData_q, sendData_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               streamStart, streamStop;
   logic [CNT_W-1:0]   streamLast;

   assign streamLast = CNT_W'(streamLen(SA_ROWS, SA_COLS, PE_LAT, 64'(k_q))) - CNT_W'(1);

   // Outputs are derived from the next state/count so they register in step with the state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      k_d         = k_q;
      streamStart = 1'b0;
      streamStop  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (i_start) begin
               k_d     = i_k_len;
               state_d = (i_k_len == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               state_d = COMMIT;
               cnt_d   = '0;
            end
         end
         COMMIT: begin
            if (cnt_q == COMMIT_LAST) begin
               state_d     = STREAM;
               cnt_d       = '0;
               streamStart = 1'b1;
            end
         end
         STREAM: begin
            if (cnt_q == streamLast) begin
               state_d    = DONE;
               cnt_d      = '0;
               streamStop = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (i_abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         cnt_d       = '0;
         streamStart = 1'b0;
         streamStop  = 1'b1;
      end

      wLoad_d   = (state_d == LOAD) && ((cnt_d % CNT_W'(PE_LAT)) == '0);
      wRowIdx_d = '0;
      if (state_d == LOAD) begin
         if (state_q != LOAD)
            wRowIdx_d = IDX_W'(SA_ROWS - 1);
         else if (wLoad_d)
            wRowIdx_d = wRowIdx_q - IDX_W'(1);
         else
            wRowIdx_d = wRowIdx_q;
      end

      sendData_d = '0;
      for (int c = 0; c < SA_COLS; c++) begin
         sendData_d[c] = (state_d == COMMIT) && (cnt_d == CNT_W'(c));
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         k_q        <= '0;
         wRowIdx_q  <= '0;
         wLoad_q    <= 1'b0;
         sendData_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         wRowIdx_q  <= wRowIdx_d;
         wLoad_q    <= wLoad_d;
         sendData_q <= sendData_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   sa_skew_gen #(
      .N       (SA_ROWS),
      .K_WIDTH (K_WIDTH),
      .CNT_W   (CNT_W),
      .BASE    (0),
      .STRIDE  (PE_LAT)
   ) aVldGen (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .start_i (streamStart),
      .stop_i  (streamStop),
      .k_i     (k_q),
      .vld_o   (o_a_vld)
   );

   // Column c's result reaches the bottom edge after all rows plus c column hops.
   sa_skew_gen #(
      .N       (SA_COLS),
      .K_WIDTH (K_WIDTH),
      .CNT_W   (CNT_W),
      .BASE    (SA_ROWS * PE_LAT),
      .STRIDE  (PE_LAT)
   ) cVldGen (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .start_i (streamStart),
      .stop_i  (streamStop),
      .k_i     (k_q),
      .vld_o   (o_c_vld)
   );

`ifdef SA_SEQ_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         perf_q <= '0;
      else if ((state_q == IDLE) && i_start)
         perf_q <= '0;
      else if ((state_q != IDLE) && (perf_q != '1))
         perf_q <= perf_q + 32'd1;
   end

   assign o_perf_cycles = perf_q;
`endif

   assign o_busy              = busy_q;
   assign o_done              = done_q;
   assign o_w_load            = wLoad_q;
   assign o_w_row_idx         = wRowIdx_q;
   assign o_ctrl_sa_send_data = sendData_q;

endmodule

// File: doc/sa_seq_ctrl.md
Name: sa_seq_ctrl

Overview:
Sequencer for the SA_ROWS x SA_COLS systolic array. For each accepted job it runs four phases:
- preloads one weight word per row down the d-chain;
- commits the weights with column-skewed pulses on the array's ctrl_sa_send_data inputs;
- streams K activation vectors into the row inputs with per-row diagonal skew;
- flags when each column's bottom c output carries a valid result.

Sits between the job scheduler (start/done handshake) and the array's edge buffers; it drives enables only, never data.

Parameters:
SA_ROWS, 3, array rows (>=1)
SA_COLS, 1, array columns (>=1)
K_WIDTH, 16, width of vector-count field
PE_LAT, 1, register stages per PE hop (>=1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_start  in  1  job request, sampled only in IDLE
i_k_len  in  K_WIDTH  number of activation vectors K, sampled with i_start
i_abort  in  1  synchronous abort, returns to IDLE
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at job end
o_w_load  out  1  weight word pushed to d inputs this cycle
o_w_row_idx  out  $clog2(SA_ROWS)+1  row whose weight is pushed (SA_ROWS-1 down to 0)
o_ctrl_sa_send_data  out  SA_COLS  weight-commit strobes to array columns
o_a_vld  out  SA_ROWS  row r edge buffer must present vector element this cycle
o_c_vld  out  SA_COLS  column c bottom output valid this cycle

Behaviour:
- Reset: i_rst_n low asynchronously forces state IDLE, all counters 0, all outputs 0.
- States: IDLE, LOAD, COMMIT, STREAM, DONE. State enum lives in the package.
- IDLE:
  - i_start=1 with i_k_len!=0 latches K and goes to LOAD next cycle.
  - i_start=1 with i_k_len==0 goes directly to DONE. No load or stream occurs.
  - i_start while busy is ignored; there is no queueing.
- LOAD: lasts SA_ROWS*PE_LAT cycles. o_w_load=1 on each PE_LAT-th cycle. o_w_row_idx starts at SA_ROWS-1 and decrements per push, so the first word pushed settles in the bottom row. Then go to COMMIT.
- COMMIT:
  - Lasts (SA_COLS-1)+SA_ROWS*PE_LAT cycles.
  - o_ctrl_sa_send_data[c] is high exactly in cycle c of COMMIT (relative 0), all other cycles low.
  - The strobe ripples down each column inside the array. The remaining cycles let the last strobe clear the bottom row. Then go to STREAM.
- STREAM (relative cycle t=0 at entry):
  - o_a_vld[r] = 1 for t in [r*PE_LAT, r*PE_LAT+K-1].
  - o_c_vld[c] = 1 for t in [(SA_ROWS+c)*PE_LAT, (SA_ROWS+c)*PE_LAT+K-1].
  - STREAM ends after t = (SA_ROWS+SA_COLS-1)*PE_LAT+K-1, then go to DONE.
  - Total STREAM length = K+(SA_ROWS+SA_COLS-1)*PE_LAT cycles.
- DONE: o_done=1 for one cycle, o_busy=1. Next state IDLE. A new i_start is accepted only in the cycle after DONE.
- i_abort: in any non-IDLE state, the next state is IDLE. All vld/strobe outputs are 0 from the next cycle, o_done is not pulsed, and i_abort has priority over normal transitions. i_abort in IDLE has no effect; i_start in the same cycle is still honoured.
- Counters:
  - STREAM counter width = K_WIDTH+$clog2(SA_ROWS+SA_COLS)+2; it must not wrap for K = 2^K_WIDTH-1.
  - Comparisons are unsigned. K is held in a register for the whole job.
- All outputs are registered: no combinational path from inputs to outputs.

Optional Feature:
SA_SEQ_CTRL_PERF_EN
- Defined: adds output o_perf_cycles (32 bits), which counts cycles from leaving IDLE to DONE inclusive. It saturates at 2^32-1, holds its value until the next accepted i_start, then clears. Reset value is 0. Abort freezes the count.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package sa_ctrl_pkg holds:
  - the state enum typedef;
  - the function returning the stream-counter width;
  - the constant functions for LOAD length, COMMIT length and STREAM length from SA_ROWS/SA_COLS/PE_LAT/K.
- One sub-module, sa_skew_gen: a generic window generator taking a start pulse, K, base offset and per-lane stride. It produces the N-lane skewed enable vector and is instantiated twice, once for o_a_vld (N=SA_ROWS, base 0) and once for o_c_vld (N=SA_COLS, base SA_ROWS*PE_LAT).

Test Plan:
- Defaults (3x1, PE_LAT=1), start with K=4:
  - LOAD 3 cycles, w_row_idx 2,1,0;
  - COMMIT 3 cycles, send_data[0] in cycle 0 only;
  - a_vld[0] t=0..3, [1] t=1..4, [2] t=2..5; c_vld[0] t=3..6;
  - done exactly one cycle after t=6 (STREAM 7 cycles);
  - busy high from cycle after start through DONE.
- SA_ROWS=4, SA_COLS=4, K=2: send_data[c] fires COMMIT cycle c; c_vld[3] high t=7..8; STREAM length 9.
- K=0 start -> done pulses the next cycle; a_vld, c_vld, w_load and send_data stay 0 throughout.
- Abort in STREAM at t=2 (defaults, K=4) -> the next cycle all outputs are 0 and state is IDLE with no done pulse; a start 1 cycle later runs a clean full job.
- i_start held high across a job -> exactly one job per IDLE visit; the second job's LOAD begins two cycles after the first done.
- Reset asserted mid-COMMIT, asynchronous and between clock edges -> outputs drop to 0 immediately; with PERF_EN, o_perf_cycles=0 after reset; a K=5 job yields o_perf_cycles = 3+3+8+1 = 15.
